// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Request/response bundle between the core's two memory ports (instruction
//   fetch "ifu" and load/store "lsu") and the memory responder.
//
//   master modport : core side (drives requests, receives responses)
//   slave modport  : memory side (receives requests, drives responses)
//
//   ifu : io_ifu_reqValid, io_ifu_addr          -> io_ifu_respValid, io_ifu_rdata
//   lsu : io_lsu_reqValid, io_lsu_addr, io_lsu_size, io_lsu_wen,
//         io_lsu_wdata, io_lsu_wmask            -> io_lsu_respValid, io_lsu_rdata
interface mem_responder_if;
    logic        io_ifu_reqValid;
    logic [31:0] io_ifu_addr;
    logic        io_ifu_respValid;
    logic [31:0] io_ifu_rdata;

    logic        io_lsu_reqValid;
    logic [31:0] io_lsu_addr;
    logic [1:0]  io_lsu_size;
    logic        io_lsu_wen;
    logic [31:0] io_lsu_wdata;
    logic [3:0]  io_lsu_wmask;
    logic        io_lsu_respValid;
    logic [31:0] io_lsu_rdata;

    modport master (
        output io_ifu_reqValid, io_ifu_addr,
        input  io_ifu_respValid, io_ifu_rdata,
        output io_lsu_reqValid, io_lsu_addr, io_lsu_size, io_lsu_wen,
               io_lsu_wdata, io_lsu_wmask,
        input  io_lsu_respValid, io_lsu_rdata
    );

    modport slave (
        input  io_ifu_reqValid, io_ifu_addr,
        output io_ifu_respValid, io_ifu_rdata,
        input  io_lsu_reqValid, io_lsu_addr, io_lsu_size, io_lsu_wen,
               io_lsu_wdata, io_lsu_wmask,
        output io_lsu_respValid, io_lsu_rdata
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder serving the core's ifu and lsu ports from a single
//   word-organised RAM. One request is in flight at a time; lsu wins over ifu
//   when both ask in the same IDLE cycle. The response arrives LATENCY cycles
//   after the accept edge and lasts exactly one cycle.
//
//   Ports:
//     clock  - sole clock, rising edge
//     reset  - synchronous, active-high (RAM contents are not cleared)
//     bus    - mem_responder_if.slave carrying both request/response ports
//
//   Parameters:
//     MEM_WORDS - RAM depth in 32-bit words (power of two, >= 16)
//     BASE_ADDR - byte address mapped to word 0
//     LATENCY   - accept edge to respValid, 1..15 cycles
//
//   Optional feature (macro MEM_RESP_LFSR_DELAY_EN):
//     An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) advances once per
//     accepted request; the two LSBs of its pre-advance value add 0..3 extra
//     WAIT cycles. Without the macro no LFSR exists and latency is LATENCY.
module mem_responder #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input logic            clock,
    input logic            reset,
    mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0] mem [MEM_WORDS];

    logic [4:0] counter;
    logic [4:0] count_load;
    logic [4:0] extra_delay;
    logic       accept;
    logic       fire;

    // Request captured at the accept edge.
    logic             op_lsu;
    logic             op_wen;
    logic             op_in_range;
    logic [IDX_W-1:0] op_index;
    logic [31:0]      op_wdata;
    logic [3:0]       op_wmask;

    // Winning incoming request, decoded.
    logic             req_any;
    logic             req_lsu;
    logic             req_wen;
    logic [31:0]      req_addr;
    logic [31:0]      req_off;
    logic             req_in_range;
    logic [IDX_W-1:0] req_index;

    // Operation performed on the edge entering RESP.
    logic             cur_lsu;
    logic             cur_wen;
    logic             cur_in_range;
    logic [IDX_W-1:0] cur_index;
    logic [31:0]      cur_wdata;
    logic [3:0]       cur_wmask;
    logic [31:0]      read_word;

    logic [31:0] ifu_rdata_q;
    logic [31:0] lsu_rdata_q;

    logic unused_ok;

    assign req_lsu  = bus.io_lsu_reqValid;
    assign req_any  = bus.io_lsu_reqValid | bus.io_ifu_reqValid;
    assign req_addr = req_lsu ? bus.io_lsu_addr : bus.io_ifu_addr;
    assign req_wen  = req_lsu & bus.io_lsu_wen;
    assign req_off  = req_addr - BASE_ADDR;

    // addr[1:0] is dropped; anything below the base or past the last word is
    // out of range and turns into a discarded write / zero read.
    assign req_in_range = (req_addr >= BASE_ADDR) &&
                          ({2'b00, req_off[31:2]} < 32'(MEM_WORDS));
    assign req_index    = req_off[IDX_W+1:2];

    assign unused_ok = ^{bus.io_lsu_size, req_off[1:0]};

`ifdef MEM_RESP_LFSR_DELAY_EN
    logic [7:0] lfsr;

    // Advance once per accepted request; the pre-advance LSBs set the delay.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign extra_delay = {3'b000, lfsr[1:0]};
`else
    assign extra_delay = 5'd0;
`endif

    assign count_load = 5'(LATENCY - 1) + extra_delay;

    // In IDLE with a zero load the request goes straight to RESP, so the
    // memory operation must use the live request rather than the latched one.
    always_comb begin
        cur_lsu      = op_lsu;
        cur_wen      = op_wen;
        cur_in_range = op_in_range;
        cur_index    = op_index;
        cur_wdata    = op_wdata;
        cur_wmask    = op_wmask;
        if (state == IDLE) begin
            cur_lsu      = req_lsu;
            cur_wen      = req_wen;
            cur_in_range = req_in_range;
            cur_index    = req_index;
            cur_wdata    = bus.io_lsu_wdata;
            cur_wmask    = bus.io_lsu_wmask;
        end
    end

    assign read_word = cur_in_range ? mem[cur_index] : 32'h0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The counter holds the WAIT cycles still to go; WAIT exits on the edge
    // where it would step from 1 down to 0.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    accept = 1'b1;
                    if (count_load == 5'd0) begin
                        next_state = RESP;
                        fire       = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (counter <= 5'd1) begin
                    next_state = RESP;
                    fire       = 1'b1;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter     <= 5'd0;
            op_lsu      <= 1'b0;
            op_wen      <= 1'b0;
            op_in_range <= 1'b0;
            op_index    <= '0;
            op_wdata    <= 32'h0;
            op_wmask    <= 4'h0;
        end else if (accept) begin
            counter     <= count_load;
            op_lsu      <= req_lsu;
            op_wen      <= req_wen;
            op_in_range <= req_in_range;
            op_index    <= req_index;
            op_wdata    <= bus.io_lsu_wdata;
            op_wmask    <= bus.io_lsu_wmask;
        end else if (state == WAIT && counter != 5'd0) begin
            counter <= counter - 5'd1;
        end
    end

    // Byte-lane store; gated by reset so an uncommitted write is dropped.
    always_ff @(posedge clock) begin
        if (!reset && fire && cur_wen && cur_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wmask[i]) begin
                    mem[cur_index][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data lands in the selected port's register; stores leave it alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            ifu_rdata_q <= 32'h0;
            lsu_rdata_q <= 32'h0;
        end else if (fire && !cur_wen) begin
            if (cur_lsu) begin
                lsu_rdata_q <= read_word;
            end else begin
                ifu_rdata_q <= read_word;
            end
        end
    end

    assign bus.io_ifu_respValid = (state == RESP) && !op_lsu;
    assign bus.io_lsu_respValid = (state == RESP) && op_lsu;
    assign bus.io_ifu_rdata     = ifu_rdata_q;

    // A store response reports zero without disturbing the held load data.
    assign bus.io_lsu_rdata = (bus.io_lsu_respValid && op_wen) ? 32'h0 : lsu_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed and randomized bench for mem_responder. Expected data come from a
//   word-addressed associative-array memory model; expected latency comes from
//   LATENCY plus, when MEM_RESP_LFSR_DELAY_EN is defined, the LFSR-derived delay.
module tb_mem_responder;

    localparam int          MEM_WORDS = 4096;
    localparam logic [31:0] BASE_ADDR = 32'h8000_0000;
    localparam int          LATENCY   = 2;
    localparam int          MAX_WAIT  = 40;

    logic clock = 1'b0;
    logic reset;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] modelMem [int];
    logic [7:0]  lfsrModel;

    always #5 clock = ~clock;

    mem_responder_if bus ();

    mem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .BASE_ADDR(BASE_ADDR),
        .LATENCY  (LATENCY)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Extra delay of the next accepted request, advancing the model LFSR.
    function automatic int nextExtra();
        int e;
`ifdef MEM_RESP_LFSR_DELAY_EN
        logic fb;
        e  = int'(lfsrModel[1:0]);
        fb = lfsrModel[7] ^ lfsrModel[5] ^ lfsrModel[4] ^ lfsrModel[3];
        lfsrModel = {lfsrModel[6:0], fb};
`else
        e = 0;
`endif
        return e;
    endfunction

    function automatic bit inRange(input logic [31:0] addr);
        longint off;
        off = longint'(addr) - longint'(BASE_ADDR);
        return (off >= 0) && ((off / 4) < MEM_WORDS);
    endfunction

    function automatic int wordOf(input logic [31:0] addr);
        return int'((longint'(addr) - longint'(BASE_ADDR)) / 4);
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        if (!inRange(addr)) return 32'h0;
        if (!modelMem.exists(wordOf(addr))) return 32'hxxxx_xxxx;
        return modelMem[wordOf(addr)];
    endfunction

    function automatic void modelWrite(input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [3:0] wmask);
        logic [31:0] w;
        if (!inRange(addr)) return;
        w = modelMem.exists(wordOf(addr)) ? modelMem[wordOf(addr)] : 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) w[8*i +: 8] = wdata[8*i +: 8];
        end
        modelMem[wordOf(addr)] = w;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        bus.io_ifu_reqValid = 1'b0;
        bus.io_ifu_addr     = 32'h0;
        bus.io_lsu_reqValid = 1'b0;
        bus.io_lsu_addr     = 32'h0;
        bus.io_lsu_size     = 2'd2;
        bus.io_lsu_wen      = 1'b0;
        bus.io_lsu_wdata    = 32'h0;
        bus.io_lsu_wmask    = 4'h0;
    endtask

    // One complete request, called and returning at a negedge with the DUT idle.
    task automatic applyStimulus(input string tag, input bit isLsu, input logic [31:0] addr,
                                 input bit wen, input logic [31:0] wdata,
                                 input logic [3:0] wmask);
        int          expLat;
        int          k;
        bit          seen;
        logic [31:0] expData;
        logic        otherResp;

        if (isLsu) begin
            bus.io_lsu_reqValid = 1'b1;
            bus.io_lsu_addr     = addr;
            bus.io_lsu_wen      = wen;
            bus.io_lsu_wdata    = wdata;
            bus.io_lsu_wmask    = wmask;
        end else begin
            bus.io_ifu_reqValid = 1'b1;
            bus.io_ifu_addr     = addr;
        end

        expLat  = LATENCY + nextExtra();
        expData = (isLsu && wen) ? 32'h0 : modelRead(addr);
        if (isLsu && wen) modelWrite(addr, wdata, wmask);

        @(posedge clock);
        k         = 0;
        seen      = 1'b0;
        otherResp = 1'b0;
        while (!seen && k < MAX_WAIT) begin
            @(negedge clock);
            k++;
            otherResp = otherResp | (isLsu ? bus.io_ifu_respValid : bus.io_lsu_respValid);
            seen = isLsu ? bus.io_lsu_respValid : bus.io_ifu_respValid;
        end

        checkOutput({tag, "_latency"}, 32'(k), 32'(expLat));
        checkOutput({tag, "_lat_range"}, 32'(k >= LATENCY && k <= LATENCY + 3), 32'd1);
        checkOutput({tag, "_other_port"}, {31'b0, otherResp}, 32'h0);
        checkOutput({tag, "_rdata"}, isLsu ? bus.io_lsu_rdata : bus.io_ifu_rdata, expData);

        idleInputs();
        @(negedge clock);
        checkOutput({tag, "_pulse_width"},
                    {31'b0, isLsu ? bus.io_lsu_respValid : bus.io_ifu_respValid}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          expL;
        int          expI;
        int          k;
        bit          seen;
        logic        spurious;
        logic [31:0] expData;
        logic [31:0] addr;

        // Reset state
        idleInputs();
        reset = 1'b1;
        lfsrModel = 8'hA5;
        repeat (3) @(negedge clock);
        checkOutput("reset_ifu_resp", {31'b0, bus.io_ifu_respValid}, 32'h0);
        checkOutput("reset_lsu_resp", {31'b0, bus.io_lsu_respValid}, 32'h0);
        checkOutput("reset_ifu_rdata", bus.io_ifu_rdata, 32'h0);
        checkOutput("reset_lsu_rdata", bus.io_lsu_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Give the low 16 words known contents
        for (int i = 0; i < 16; i++) begin
            applyStimulus("init_store", 1'b1, BASE_ADDR + 32'(4 * i), 1'b1, $urandom, 4'hF);
        end

        // Full-word store then fetch, byte-lane store then load
        applyStimulus("t1_store", 1'b1, 32'h8000_0010, 1'b1, 32'hDEADBEEF, 4'hF);
        applyStimulus("t1_fetch", 1'b0, 32'h8000_0010, 1'b0, 32'h0, 4'h0);
        checkOutput("t1_fetch_value", bus.io_ifu_rdata, 32'hDEADBEEF);
        applyStimulus("t2_byte_store", 1'b1, 32'h8000_0010, 1'b1, 32'h00AB0000, 4'b0100);
        applyStimulus("t2_load", 1'b1, 32'h8000_0010, 1'b0, 32'h0, 4'h0);
        checkOutput("t2_load_value", bus.io_lsu_rdata, 32'hDEABBEEF);
        applyStimulus("zero_mask_store", 1'b1, 32'h8000_0010, 1'b1, 32'h1111_1111, 4'h0);
        applyStimulus("zero_mask_load", 1'b1, 32'h8000_0012, 1'b0, 32'h0, 4'h0);

        // Simultaneous requests: lsu first, ifu LATENCY+1 cycles later
        bus.io_ifu_reqValid = 1'b1;
        bus.io_ifu_addr     = 32'h8000_0004;
        bus.io_lsu_reqValid = 1'b1;
        bus.io_lsu_addr     = 32'h8000_0008;
        bus.io_lsu_wen      = 1'b0;
        expL    = LATENCY + nextExtra();
        expData = modelRead(32'h8000_0008);
        @(posedge clock);
        k = 0;
        seen = 1'b0;
        spurious = 1'b0;
        while (!seen && k < MAX_WAIT) begin
            @(negedge clock);
            k++;
            spurious = spurious | bus.io_ifu_respValid;
            seen = bus.io_lsu_respValid;
        end
        checkOutput("t3_lsu_latency", 32'(k), 32'(expL));
        checkOutput("t3_lsu_rdata", bus.io_lsu_rdata, expData);
        checkOutput("t3_ifu_early", {31'b0, spurious}, 32'h0);
        bus.io_lsu_reqValid = 1'b0;
        expI    = 1 + LATENCY + nextExtra();
        expData = modelRead(32'h8000_0004);
        k = 0;
        seen = 1'b0;
        spurious = 1'b0;
        while (!seen && k < MAX_WAIT) begin
            @(negedge clock);
            k++;
            spurious = spurious | bus.io_lsu_respValid;
            seen = bus.io_ifu_respValid;
        end
        checkOutput("t3_ifu_gap", 32'(k), 32'(expI));
        checkOutput("t3_lsu_single_pulse", {31'b0, spurious}, 32'h0);
        checkOutput("t3_ifu_rdata", bus.io_ifu_rdata, expData);
        idleInputs();
        @(negedge clock);
        checkOutput("t3_ifu_pulse_width", {31'b0, bus.io_ifu_respValid}, 32'h0);

        // Out-of-range accesses
        applyStimulus("t4_load_below", 1'b1, 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0);
        applyStimulus("t4_load_above", 1'b1, BASE_ADDR + 32'(4 * MEM_WORDS), 1'b0, 32'h0, 4'h0);
        applyStimulus("t4_fetch_above", 1'b0, BASE_ADDR + 32'(4 * MEM_WORDS), 1'b0, 32'h0, 4'h0);
        applyStimulus("t4_store_above", 1'b1, BASE_ADDR + 32'(4 * MEM_WORDS), 1'b1,
                      32'hCAFE_F00D, 4'hF);
        applyStimulus("t4_store_below", 1'b1, 32'h7FFF_FFFC, 1'b1, 32'hCAFE_F00D, 4'hF);
        applyStimulus("t4_word0", 1'b1, BASE_ADDR, 1'b0, 32'h0, 4'h0);

        // Reset during WAIT abandons the store
        bus.io_lsu_reqValid = 1'b1;
        bus.io_lsu_addr     = 32'h8000_0014;
        bus.io_lsu_wen      = 1'b1;
        bus.io_lsu_wdata    = 32'h1234_5678;
        bus.io_lsu_wmask    = 4'hF;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        idleInputs();
        @(negedge clock);
        reset = 1'b0;
        lfsrModel = 8'hA5;
        spurious = bus.io_lsu_respValid | bus.io_ifu_respValid;
        checkOutput("t5_lsu_rdata_cleared", bus.io_lsu_rdata, 32'h0);
        repeat (LATENCY + 4) begin
            @(negedge clock);
            spurious = spurious | bus.io_lsu_respValid | bus.io_ifu_respValid;
        end
        checkOutput("t5_no_resp", {31'b0, spurious}, 32'h0);
        applyStimulus("t5_old_value", 1'b1, 32'h8000_0014, 1'b0, 32'h0, 4'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            bit lsuSel;
            bit wenSel;
            lsuSel = 1'($urandom_range(0, 1));
            wenSel = lsuSel && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) begin
                addr = ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFF0 + 32'($urandom_range(0, 15))
                                                   : BASE_ADDR + 32'(4 * MEM_WORDS)
                                                     + 32'($urandom_range(0, 255));
            end else begin
                addr = BASE_ADDR + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            end
            applyStimulus("rand", lsuSel, addr, wenSel, $urandom, 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
